// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the toggle-strobe data-memory responder.
package mem_resp_pkg;

  // Responder sequencing states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_WAIT
  } state_e;

  // funct3 size codes
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // Number of byte cycles for an access, from the low two size bits
  function automatic logic [2:0] size_to_nb(input logic [1:0] size_lo);
    case (size_lo)
      2'b00:   size_to_nb = 3'd1;
      2'b01:   size_to_nb = 3'd2;
      default: size_to_nb = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Issuer-side request bus: toggle strobes, request fields, busy and load result.
interface mem_responder_if;
  logic        mem_clk;
  logic        mem_rd_clk;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_wait;
  logic [31:0] rdata;

  modport master (
    output mem_clk, mem_rd_clk, size, addr, wdata,
    input  mem_wait, rdata
  );

  modport slave (
    input  mem_clk, mem_rd_clk, size, addr, wdata,
    output mem_wait, rdata
  );
endinterface

// File: rtl/mem_sx_extend.sv
// Load-result extension: byte/half sign or zero extension, otherwise full word.
module mem_sx_extend
  import mem_resp_pkg::*;
(
  input  logic [31:0] assembly,
  input  logic [2:0]  size,
  output logic [31:0] result
);

  // Select the extension from the funct3 size code
  always_comb begin
    result = assembly;
    case (size)
      SZ_B:    result = {{24{assembly[7]}}, assembly[7:0]};
      SZ_H:    result = {{16{assembly[15]}}, assembly[15:0]};
      SZ_BU:   result = {24'h000000, assembly[7:0]};
      SZ_HU:   result = {16'h0000, assembly[15:0]};
      SZ_W:    result = assembly;
      default: result = assembly;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: turns strobe toggles into bytewise SRAM accesses.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_in,
  mem_responder_if.slave    bus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  output logic              sram_en,
  output logic              sram_we,
  input  logic [7:0]        sram_rdata
);

  localparam logic [2:0] LAT_INIT = 3'(READ_LAT);

  state_e            state_q, state_d;
  logic              st_seen_q, st_seen_d;
  logic              ld_seen_q, ld_seen_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        nb_q, nb_d;
  logic [1:0]        bi_q, bi_d;
  logic [2:0]        lat_q, lat_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              st_pend, ld_pend, last_byte;
  logic [31:0]       asm_merged, ext_word;
  logic              unused_addr_hi;

  // Request address is truncated to the SRAM width; upper bits carry no meaning here
  assign unused_addr_hi = ^bus.addr[31:ADDR_W];

  assign st_pend      = bus.mem_clk ^ st_seen_q;
  assign ld_pend      = bus.mem_rd_clk ^ ld_seen_q;
  assign bus.mem_wait = st_pend | ld_pend | (state_q != ST_IDLE);
  assign bus.rdata    = rdata_q;
  assign last_byte    = ({1'b0, bi_q} == (nb_q - 3'd1));

  // Assembly word with the incoming SRAM byte placed at the current byte index
  always_comb begin
    asm_merged = asm_q;
    asm_merged[{bi_q, 3'b000} +: 8] = sram_rdata;
  end

  mem_sx_extend u_ext (
    .assembly (asm_merged),
    .size     (size_q),
    .result   (ext_word)
  );

  // Next-state, capture and SRAM strobe decode
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    st_seen_d  = st_seen_q;
    ld_seen_d  = ld_seen_q;
    base_d     = base_q;
    size_d     = size_q;
    wdata_d    = wdata_q;
    nb_d       = nb_q;
    bi_d       = bi_q;
    lat_d      = lat_q;
    asm_d      = asm_q;
    rdata_d    = rdata_q;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = 8'h00;

    case (state_q)
      ST_IDLE: begin
        // Stores win when both strobes are pending; the load stays pending
        if (st_pend || ld_pend) begin
          base_d = bus.addr[ADDR_W-1:0];
          size_d = bus.size;
          wdata_d = bus.wdata;
          nb_d   = size_to_nb(bus.size[1:0]);
          bi_d   = 2'd0;
          if (st_pend) begin
            st_seen_d = ~st_seen_q;
            state_d   = ST_WR;
          end else begin
            ld_seen_d = ~ld_seen_q;
            asm_d     = '0;
            state_d   = ST_RD_ISSUE;
          end
        end
      end

      ST_WR: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = base_q + ADDR_W'(bi_q);
        sram_wdata = wdata_q[{bi_q, 3'b000} +: 8];
        bi_d       = bi_q + 2'd1;
        if (last_byte) state_d = ST_IDLE;
      end

      ST_RD_ISSUE: begin
        sram_en   = 1'b1;
        sram_addr = base_q + ADDR_W'(bi_q);
        lat_d     = LAT_INIT;
        state_d   = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          asm_d = asm_merged;
          bi_d  = bi_q + 2'd1;
          if (last_byte) begin
            rdata_d = ext_word;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RD_ISSUE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge reset_in) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset_in) begin
      state_q   <= ST_IDLE;
      st_seen_q <= 1'b0;
      ld_seen_q <= 1'b0;
      base_q    <= '0;
      size_q    <= 3'b000;
      wdata_q   <= 32'h0;
      nb_q      <= 3'd1;
      bi_q      <= 2'd0;
      lat_q     <= 3'd0;
      asm_q     <= 32'h0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      st_seen_q <= st_seen_d;
      ld_seen_q <= ld_seen_d;
      base_q    <= base_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      nb_q      <= nb_d;
      bi_q      <= bi_d;
      lat_q     <= lat_d;
      asm_q     <= asm_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's toggle-strobe data-memory interface.
- Detects store requests (`mem_clk` toggle) and load requests (`mem_rd_clk` toggle), holds `mem_wait` high while busy, and performs the access as sequential byte cycles on a byte-wide synchronous SRAM.
- Loads return a sign- or zero-extended `rdata` according to the funct3 size code.
- Sits between `control_fsm`/datapath and on-chip or external data SRAM.

Parameters:
- ADDR_W, 16, SRAM byte-address width; the request address is truncated to its low ADDR_W bits.
- READ_LAT, 1, SRAM read latency in cycles from the `sram_en` cycle to `sram_rdata` valid; legal range 1..4.

Ports:
- clk  in  1  system clock
- reset_in  in  1  asynchronous, active-high reset
- mem_clk  in  1  store strobe; every level change (either direction) is one store request
- mem_rd_clk  in  1  load strobe; every level change is one load request
- size  in  3  funct3 size code, sampled at request capture
- addr  in  32  byte address, sampled at capture
- wdata  in  32  store data, sampled at capture
- mem_wait  out  1  busy; stalls the issuer
- rdata  out  32  extended load result
- sram_addr  out  ADDR_W  SRAM byte address
- sram_wdata  out  8  SRAM write byte
- sram_en  out  1  SRAM access enable
- sram_we  out  1  SRAM write enable (only valid with `sram_en`)
- sram_rdata  in  8  SRAM read byte

Behaviour:
- Reset values: `mem_wait`=0, `rdata`=0, `sram_en`=0, `sram_we`=0, `sram_addr`=0, `sram_wdata`=0. State is IDLE. The seen-copies `st_seen` and `ld_seen` are 0. The issuer drives both strobes low during reset.
- Pending flags are combinational:
  - `st_pend` = `mem_clk` XOR `st_seen`
  - `ld_pend` = `mem_rd_clk` XOR `ld_seen`
- `mem_wait` is combinational and equals `st_pend` OR `ld_pend` OR (state != IDLE). It is therefore high in the first cycle after a strobe toggle, with no lag.
- Capture happens in IDLE with a pending request:
  - Latch `addr`[ADDR_W-1:0], `size`, `wdata`.
  - Flip the matching seen-copy.
  - Set the byte counter `nb` from `size`[1:0]: 00→1, 01→2, 10 or 11→4.
  - Set byte index `bi`=0.
- Arbitration: if both are pending, the store is served first and the load on the following IDLE capture.
- States:
  - IDLE: on capture, go to WR or RD_ISSUE.
  - WR:
    - `sram_en`=1, `sram_we`=1, `sram_addr`=base+`bi`, `sram_wdata`=`wdata` byte `bi` (little-endian).
    - `bi`++.
    - When `bi`=`nb`-1, return to IDLE.
  - RD_ISSUE:
    - `sram_en`=1, `sram_we`=0, `sram_addr`=base+`bi`.
    - Go to RD_WAIT with latency counter = READ_LAT.
  - RD_WAIT:
    - Decrement the latency counter.
    - At 0, latch `sram_rdata` into assembly byte `bi`, then `bi`++.
    - If more bytes remain, go to RD_ISSUE; otherwise update `rdata` and go to IDLE.
- SRAM outputs are driven combinationally from state/registers. `sram_en`=0 outside WR/RD_ISSUE.
- Latency (capture cycle included):
  - Store: 1+`nb` cycles of `mem_wait`.
  - Load: 1+`nb`·(1+READ_LAT) cycles.
- Address arithmetic wraps modulo 2^ADDR_W. Misaligned accesses are legal and handled bytewise.
- Extension, applied once at load completion:
  - 000 sign-extend byte
  - 001 sign-extend half
  - 100 zero-extend byte
  - 101 zero-extend half
  - 010, 011, 110, 111 full word
- `rdata` holds its value until the next load completes. Stores never change `rdata`.
- A toggle arriving while busy stays pending: its seen-copy has not flipped, so `mem_wait` stays high. It is served on return to IDLE.
- A double toggle (two level changes) between samples is indistinguishable from none. The issuer guarantees at most one toggle per strobe per request, gated by `mem_wait`.
- Reset mid-operation aborts immediately:
  - The SRAM strobes drop.
  - Partial store bytes already written remain written.
  - `rdata` returns to 0.
  - There is no replay.

Decomposition:
- Package `mem_resp_pkg`:
  - state encoding (IDLE, WR, RD_ISSUE, RD_WAIT)
  - size constants SZ_B=000, SZ_H=001, SZ_W=010, SZ_BU=100, SZ_HU=101
  - function mapping `size` to `nb`
- Sub-module `mem_sx_extend`: combinational 32-bit assembly plus `size` in, extended 32-bit out.

Test Plan:
1. Word round trip (READ_LAT=1): SW 0x12345678 @0x0010 → SRAM 0x10..0x13 = 78,56,34,12; `mem_wait` high 5 cycles. LW @0x0010 → `rdata`=0x12345678; `mem_wait` high 9 cycles.
2. Byte extension: SB 0x80 @0x0013, then LB @0x0013 → `rdata`=0xFFFFFF80. LBU @0x0013 → 0x00000080. LH @0x0012 → 0xFFFF8034.
3. Misaligned half with wrap (ADDR_W=16): SH 0xBEEF @0xFFFF → 0xEF@0xFFFF, 0xBE@0x0000. LHU @0xFFFF → 0x0000BEEF.
4. Simultaneous toggle: `mem_clk` and `mem_rd_clk` toggle in the same cycle (SW 0xA5A5A5A5 @0x40, LW @0x40) → store completes first, then `rdata`=0xA5A5A5A5. `mem_wait` stays high continuously, 14 cycles total.
5. Toggle while busy, READ_LAT=3: toggle `mem_rd_clk` mid-load → the second load is served after the first. `mem_wait` never drops between them. Each LW takes 17 cycles.
6. Reset mid-load: assert `reset_in` during the RD_WAIT of byte 2 → `mem_wait`, `sram_en`, `rdata` all read 0 within the same cycle. The next LW returns correct data.
